fifo_rd_stream: RTL and testbench

//  Read-side drain engine for the fifo_ctrl + synchronous-read RAM pair.

---
 rtl/fifo_rd_stream.sv | 92 +++++++++
 tb/tb_fifo_rd_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pulls words from a fifo_ctrl + sync-read RAM pair and
// presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            buf_cnt
);

   logic [1:0]            cnt_reg;
   logic [1:0]            cnt_next;
   logic                  inflight_reg;
   logic [DATA_WIDTH-1:0] slot_reg  [2];
   logic [DATA_WIDTH-1:0] slot_next [2];

   logic       pop;
   logic       push;
   logic [1:0] wr_idx;
   logic [2:0] occ;

   assign out_valid = (cnt_reg != 2'd0);
   assign pop       = out_valid && out_ready;
   assign push      = inflight_reg && !flush;

   // Occupancy once the in-flight word lands and this cycle's pop leaves;
   // requesting only below 2 guarantees every returning word has a slot.
   assign occ        = {1'b0, cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign fifo_rd_en = !rst && !flush && !fifo_empty && (occ < 3'd2);

   // Tail position for an arriving word after the head has (maybe) shifted out.
   assign wr_idx = cnt_reg - {1'b0, pop};

   always_comb begin
      cnt_next = cnt_reg;
      if (flush) begin
         cnt_next = 2'd0;
      end else begin
         cnt_next = cnt_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_slot
         logic [DATA_WIDTH-1:0] shift_src;
         if (gi == 1) begin : gen_top
            assign shift_src = slot_reg[gi];
         end else begin : gen_lower
            assign shift_src = slot_reg[gi+1];
         end
         assign slot_next[gi] = (push && (wr_idx == 2'(gi))) ? fifo_rdata :
                                pop                           ? shift_src  :
                                                                slot_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg      <= 2'd0;
         inflight_reg <= 1'b0;
         slot_reg[0]  <= '0;
         slot_reg[1]  <= '0;
      end else begin
         cnt_reg      <= cnt_next;
         inflight_reg <= fifo_rd_en;
         slot_reg[0]  <= slot_next[0];
         slot_reg[1]  <= slot_next[1];
      end
   end

   assign out_data = slot_reg[0];
   assign buf_cnt  = cnt_reg;

   // Protocol invariants that the occupancy rule above is meant to uphold.
   a_no_rd_when_empty : assert property (@(posedge clk) disable iff (rst)
      fifo_empty |-> !fifo_rd_en);
   a_cnt_range : assert property (@(posedge clk) disable iff (rst)
      cnt_reg <= 2'd2);
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (push && !pop) |-> (cnt_reg < 2'd2));
   a_hold : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO/RAM model feeding a scoreboard of words read,
// plus directed latency, backpressure and flush scenarios.
module tb_fifo_rd_stream;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         fifo_empty;
   logic         fifo_rd_en;
   logic [W-1:0] fifo_rdata;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   buf_cnt;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .buf_cnt    (buf_cnt)
   );

   logic [7:0] mem [256];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       rd_s = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_word;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int         n_checks = 0;
   int         n_pass = 0;
   int         beats = 0;
   int         start_rd;

   assign fifo_empty = (wr_ptr == rd_ptr);

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(logic [7:0] v);
      mem[wr_ptr[7:0]] = v;
      wr_ptr++;
   endtask

   task automatic wait_valid(string tag, int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic wait_drain(string tag);
      int quiet = 0;
      for (int i = 0; i < 300 && quiet < 4; i++) begin
         @(negedge clk);
         if (fifo_empty && exp_q.size() == 0 && !out_valid) quiet++;
         else quiet = 0;
      end
      check({tag, "_drained"}, 32'(quiet >= 4), 32'd1);
      check({tag, "_cnt_idle"}, 32'(buf_cnt), 32'd0);
   endtask

   // FIFO/RAM model: the pointer advances on the read edge, data follows a cycle later
   always @(posedge clk) begin
      if (rd_s) begin
         fifo_rdata <= mem[rd_ptr[7:0]];
         exp_q.push_back(mem[rd_ptr[7:0]]);
         rd_ptr <= rd_ptr + 1;
      end
   end

   // Mid-cycle monitor: protocol guards, hold rule, scoreboard compare
   always @(negedge clk) begin
      rd_s <= fifo_rd_en;
      if (rst || fifo_empty || flush) check("rd_en_guard", 32'(fifo_rd_en), 32'd0);
      check("buf_cnt_range", 32'(buf_cnt <= 2'd2), 32'd1);
      if (prev_hold && !rst) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'(prev_data));
      end
      prev_hold <= out_valid && !out_ready && !flush && !rst;
      prev_data <= out_data;
      if (out_valid && out_ready && !rst) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_word = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(exp_word));
            $display("beat %0d data=0x%02h expected=0x%02h", beats, out_data, exp_word);
         end
         beats++;
      end
      if (flush || rst) exp_q.delete();
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      out_ready  = 1'b1;
      fifo_rdata = '0;
      push_word(8'h5A);

      // T1: reset held with a non-empty FIFO
      repeat (3) begin
         @(negedge clk);
         check("t1_rd_en", 32'(fifo_rd_en), 32'd0);
         check("t1_valid", 32'(out_valid), 32'd0);
         check("t1_cnt", 32'(buf_cnt), 32'd0);
         check("t1_data", 32'(out_data), 32'd0);
      end
      step();
      rst = 1'b0;
      wait_drain("t1");

      // T2: single word latency
      step();
      push_word(8'hA5);
      @(negedge clk);
      check("t2_rd_c0", 32'(fifo_rd_en), 32'd1);
      check("t2_valid_c0", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("t2_rd_c1", 32'(fifo_rd_en), 32'd0);
      check("t2_valid_c1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("t2_valid_c2", 32'(out_valid), 32'd1);
      check("t2_data_c2", 32'(out_data), 32'hA5);
      wait_drain("t2");

      // T3: 16-word stream without bubbles
      step();
      for (int i = 0; i < 16; i++) push_word(8'(i));
      wait_valid("t3_first", 10);
      check("t3_data", 32'(out_data), 32'd0);
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         check("t3_no_gap", 32'(out_valid), 32'd1);
         check("t3_data", 32'(out_data), 32'(k));
      end
      wait_drain("t3");

      // T4: backpressure fills the buffer and stops reads
      step();
      out_ready = 1'b0;
      start_rd  = rd_ptr;
      for (int i = 0; i < 4; i++) push_word(8'(i));
      repeat (6) @(negedge clk);
      check("t4_cnt", 32'(buf_cnt), 32'd2);
      check("t4_reads", 32'(rd_ptr - start_rd), 32'd2);
      check("t4_valid", 32'(out_valid), 32'd1);
      repeat (3) begin
         @(negedge clk);
         check("t4_head", 32'(out_data), 32'd0);
      end
      step();
      out_ready = 1'b1;
      wait_drain("t4");

      // T5: FIFO runs empty mid-stream, then random trickle with random ready
      step();
      for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i));
      repeat (8) step();
      for (int i = 0; i < 4; i++) push_word(8'h24 + 8'(i));
      for (int c = 0; c < 60; c++) begin
         step();
         out_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) push_word(8'h40 + 8'(c));
      end
      step();
      out_ready = 1'b1;
      wait_drain("t5");

      // T6: flush with a word in flight, then with a full buffer
      step();
      out_ready = 1'b0;
      start_rd  = rd_ptr;
      for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
      step();
      step();
      flush = 1'b1;
      @(negedge clk);
      check("t6_pre_cnt", 32'(buf_cnt), 32'd1);
      check("t6_rd_in_flush", 32'(fifo_rd_en), 32'd0);
      step();
      flush = 1'b0;
      @(negedge clk);
      check("t6_cnt_after", 32'(buf_cnt), 32'd0);
      check("t6_valid_after", 32'(out_valid), 32'd0);
      repeat (4) @(negedge clk);
      check("t6_refill_cnt", 32'(buf_cnt), 32'd2);
      check("t6_refill_head", 32'(out_data), 32'h32);
      check("t6_reads", 32'(rd_ptr - start_rd), 32'd4);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("t6_cnt_after2", 32'(buf_cnt), 32'd0);
      check("t6_valid_after2", 32'(out_valid), 32'd0);
      step();
      push_word(8'h34);
      out_ready = 1'b1;
      wait_valid("t6_resume", 10);
      check("t6_resume_data", 32'(out_data), 32'h34);
      wait_drain("t6");

      // Every word written except the four dropped by the two flushes
      check("total_beats", 32'(beats), 32'(wr_ptr - 4));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
